// File: rtl/mvm_axis_loader.sv
// Command queue and AXI-Stream master that packs typed rtl_mvm commands into single-beat packets.
// Defining MVM_LOADER_STATS_EN adds per-op counters of completed handshakes.
module mvm_axis_loader #(
    parameter int DATAW   = 512,
    parameter int BYTEW   = 8,
    parameter int IDW     = 32,
    parameter int DESTW   = 12,
    parameter int USERW   = 75,
    parameter int RFADDRW = 9,
    parameter int NRF     = 64,
    parameter int INSTW   = 32,
    parameter int CMDD    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [RFADDRW-1:0]       cmd_rf_addr,
    input  logic [NRF-1:0]           cmd_rf_mask,
    input  logic [DATAW-1:0]         cmd_data,
    input  logic [DESTW-1:0]         cmd_dest,
    output logic [$clog2(CMDD):0]    cmd_count,
    output logic                     axis_tx_tvalid,
    output logic [DATAW-1:0]         axis_tx_tdata,
    output logic [BYTEW-1:0]         axis_tx_tstrb,
    output logic [BYTEW-1:0]         axis_tx_tkeep,
    output logic [IDW-1:0]           axis_tx_tid,
    output logic [DESTW-1:0]         axis_tx_tdest,
    output logic [USERW-1:0]         axis_tx_tuser,
    output logic                     axis_tx_tlast,
    input  logic                     axis_tx_tready
`ifdef MVM_LOADER_STATS_EN
    ,
    output logic [31:0]              stat_rf_cnt,
    output logic [31:0]              stat_vec_cnt,
    output logic [31:0]              stat_red_cnt,
    output logic [31:0]              stat_inst_cnt
`endif
);
    localparam int PTRW = $clog2(CMDD);
    localparam int CNTW = $clog2(CMDD) + 1;

    typedef enum logic {ST_EMPTY, ST_VALID} state_t;
    state_t state, next_state;

    logic [1:0]         op_mem   [CMDD];
    logic [RFADDRW-1:0] addr_mem [CMDD];
    logic [NRF-1:0]     mask_mem [CMDD];
    logic [DATAW-1:0]   data_mem [CMDD];
    logic [DESTW-1:0]   dest_mem [CMDD];

    logic [PTRW-1:0]  wr_ptr, rd_ptr;
    logic [CNTW-1:0]  count, count_next;
    logic             ready_q, push, load, handshake, empty;
    logic [IDW-1:0]   tid;
    logic [1:0]       head_op;
    logic             head_is_rf;
    logic [USERW-1:0] head_user;
    logic [DATAW-1:0] head_data;

    // ready_q tracks "not full" one edge ahead; rst only masks it so the queue is open right after reset.
    assign cmd_ready      = ready_q && !rst;
    assign push           = cmd_valid && cmd_ready;
    assign empty          = (count == '0);
    assign cmd_count      = count;
    assign axis_tx_tvalid = (state == ST_VALID);
    assign axis_tx_tid    = tid;

    always_comb begin
        count_next = count;
        case ({push, load})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]   <= cmd_op;
            addr_mem[wr_ptr] <= cmd_rf_addr;
            mask_mem[wr_ptr] <= cmd_rf_mask;
            data_mem[wr_ptr] <= cmd_data;
            dest_mem[wr_ptr] <= cmd_dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTRW'(1);
            if (load) rd_ptr <= rd_ptr + PTRW'(1);
            count   <= count_next;
            ready_q <= (count_next != CNTW'(CMDD));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= next_state;
    end

    // A completed beat immediately reloads from the queue so packets stream at one per cycle.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        handshake  = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (!empty) begin
                    load       = 1'b1;
                    next_state = ST_VALID;
                end
            end
            ST_VALID: begin
                if (axis_tx_tready) begin
                    handshake = 1'b1;
                    if (!empty) load = 1'b1;
                    else        next_state = ST_EMPTY;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    assign head_op    = op_mem[rd_ptr];
    assign head_is_rf = (head_op == 2'b11);
    assign head_user  = {head_is_rf ? mask_mem[rd_ptr] : {NRF{1'b0}},
                         head_op,
                         head_is_rf ? addr_mem[rd_ptr] : {RFADDRW{1'b0}}};
    assign head_data  = (head_op == 2'b00) ? {{(DATAW-INSTW){1'b0}}, data_mem[rd_ptr][INSTW-1:0]}
                                           : data_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            axis_tx_tdata <= '0;
            axis_tx_tuser <= '0;
            axis_tx_tdest <= '0;
            axis_tx_tstrb <= '0;
            axis_tx_tkeep <= '0;
            axis_tx_tlast <= 1'b0;
            tid           <= '0;
        end else begin
            if (handshake) tid <= tid + IDW'(1);
            if (load) begin
                axis_tx_tdata <= head_data;
                axis_tx_tuser <= head_user;
                axis_tx_tdest <= dest_mem[rd_ptr];
                axis_tx_tstrb <= '1;
                axis_tx_tkeep <= '1;
                axis_tx_tlast <= 1'b1;
            end
        end
    end

`ifdef MVM_LOADER_STATS_EN
    logic [1:0] sent_op;
    assign sent_op = axis_tx_tuser[RFADDRW+1:RFADDRW];

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rf_cnt   <= '0;
            stat_vec_cnt  <= '0;
            stat_red_cnt  <= '0;
            stat_inst_cnt <= '0;
        end else if (handshake) begin
            case (sent_op)
                2'b11:   stat_rf_cnt   <= stat_rf_cnt + 32'd1;
                2'b10:   stat_vec_cnt  <= stat_vec_cnt + 32'd1;
                2'b01:   stat_red_cnt  <= stat_red_cnt + 32'd1;
                default: stat_inst_cnt <= stat_inst_cnt + 32'd1;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_mvm_axis_loader.sv
// Randomized and directed bench for mvm_axis_loader against a queue-based packet model.
// Defining MVM_LOADER_STATS_EN also exercises the stat counters.
module tb_mvm_axis_loader;
    localparam int DATAW   = 512;
    localparam int BYTEW   = 8;
    localparam int IDW     = 32;
    localparam int DESTW   = 12;
    localparam int USERW   = 75;
    localparam int RFADDRW = 9;
    localparam int NRF     = 64;
    localparam int INSTW   = 32;
    localparam int CMDD    = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic [1:0]            cmd_op = '0;
    logic [RFADDRW-1:0]    cmd_rf_addr = '0;
    logic [NRF-1:0]        cmd_rf_mask = '0;
    logic [DATAW-1:0]      cmd_data = '0;
    logic [DESTW-1:0]      cmd_dest = '0;
    logic [$clog2(CMDD):0] cmd_count;
    logic                  axis_tx_tvalid;
    logic [DATAW-1:0]      axis_tx_tdata;
    logic [BYTEW-1:0]      axis_tx_tstrb;
    logic [BYTEW-1:0]      axis_tx_tkeep;
    logic [IDW-1:0]        axis_tx_tid;
    logic [DESTW-1:0]      axis_tx_tdest;
    logic [USERW-1:0]      axis_tx_tuser;
    logic                  axis_tx_tlast;
    logic                  axis_tx_tready = 1'b0;
`ifdef MVM_LOADER_STATS_EN
    logic [31:0] stat_rf_cnt, stat_vec_cnt, stat_red_cnt, stat_inst_cnt;
`endif

    mvm_axis_loader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rf_addr(cmd_rf_addr), .cmd_rf_mask(cmd_rf_mask), .cmd_data(cmd_data),
        .cmd_dest(cmd_dest), .cmd_count(cmd_count),
        .axis_tx_tvalid(axis_tx_tvalid), .axis_tx_tdata(axis_tx_tdata),
        .axis_tx_tstrb(axis_tx_tstrb), .axis_tx_tkeep(axis_tx_tkeep),
        .axis_tx_tid(axis_tx_tid), .axis_tx_tdest(axis_tx_tdest),
        .axis_tx_tuser(axis_tx_tuser), .axis_tx_tlast(axis_tx_tlast),
        .axis_tx_tready(axis_tx_tready)
`ifdef MVM_LOADER_STATS_EN
        ,
        .stat_rf_cnt(stat_rf_cnt), .stat_vec_cnt(stat_vec_cnt),
        .stat_red_cnt(stat_red_cnt), .stat_inst_cnt(stat_inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [USERW-1:0] user;
        logic [DESTW-1:0] dest;
    } beat_t;

    beat_t            exp_q[$];
    int               checks = 0;
    int               failures = 0;
    int               sent = 0;
    int               beat_cnt = 0;
    bit               pushed = 1'b0;
    bit               stall_v = 1'b0;
    logic [DATAW-1:0] snap_data;
    logic [USERW-1:0] snap_user;
    logic [DESTW-1:0] snap_dest;
    logic [IDW-1:0]   snap_tid;

    task automatic checkOutput(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet the receiver should see for a command, straight from the encoding rules.
    function automatic beat_t encode(input logic [1:0] op, input logic [RFADDRW-1:0] addr,
                                     input logic [NRF-1:0] mask, input logic [DATAW-1:0] data,
                                     input logic [DESTW-1:0] dest);
        beat_t b;
        b.dest = dest;
        b.data = (op == 2'b00) ? (data & {{(DATAW-INSTW){1'b0}}, {INSTW{1'b1}}}) : data;
        b.user = (op == 2'b11) ? {mask, op, addr} : {{NRF{1'b0}}, op, {RFADDRW{1'b0}}};
        return b;
    endfunction

    function automatic logic [DATAW-1:0] randData();
        logic [DATAW-1:0] d;
        for (int i = 0; i < DATAW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic setRandomCmd();
        cmd_op      = 2'($urandom_range(0, 3));
        cmd_rf_addr = RFADDRW'($urandom);
        cmd_rf_mask = ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom};
        cmd_data    = randData();
        cmd_dest    = DESTW'($urandom);
    endtask

    task automatic monitor();
        beat_t e;
        int    occ;
        occ = int'(cmd_count) + int'(axis_tx_tvalid);
        checkOutput("occupancy", DATAW'(occ), DATAW'(exp_q.size()));
        if (stall_v) begin
            checkOutput("hold_tvalid", DATAW'(axis_tx_tvalid), DATAW'(1'b1));
            checkOutput("hold_tdata", axis_tx_tdata, snap_data);
            checkOutput("hold_tuser", DATAW'(axis_tx_tuser), DATAW'(snap_user));
            checkOutput("hold_tdest", DATAW'(axis_tx_tdest), DATAW'(snap_dest));
            checkOutput("hold_tid", DATAW'(axis_tx_tid), DATAW'(snap_tid));
        end
        if (axis_tx_tvalid && axis_tx_tready) begin
            checkOutput("beat_expected", DATAW'(exp_q.size() > 0), DATAW'(1'b1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("beat_tdata", axis_tx_tdata, e.data);
                checkOutput("beat_tuser", DATAW'(axis_tx_tuser), DATAW'(e.user));
                checkOutput("beat_tdest", DATAW'(axis_tx_tdest), DATAW'(e.dest));
                checkOutput("beat_tid", DATAW'(axis_tx_tid), DATAW'(IDW'(sent)));
                checkOutput("beat_tlast", DATAW'(axis_tx_tlast), DATAW'(1'b1));
                checkOutput("beat_tkeep", DATAW'(axis_tx_tkeep), DATAW'({BYTEW{1'b1}}));
                checkOutput("beat_tstrb", DATAW'(axis_tx_tstrb), DATAW'({BYTEW{1'b1}}));
            end
            sent++;
            beat_cnt++;
        end
        stall_v   = axis_tx_tvalid && !axis_tx_tready;
        snap_data = axis_tx_tdata;
        snap_user = axis_tx_tuser;
        snap_dest = axis_tx_tdest;
        snap_tid  = axis_tx_tid;
        if (cmd_valid && cmd_ready) begin
            exp_q.push_back(encode(cmd_op, cmd_rf_addr, cmd_rf_mask, cmd_data, cmd_dest));
            pushed = 1'b1;
        end
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic step();
        logic was_rst;
        @(negedge clk);
        was_rst = rst;
        if (!was_rst) monitor();
        @(posedge clk);
        #1;
        if (was_rst) begin
            exp_q.delete();
            sent    = 0;
            stall_v = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [RFADDRW-1:0] addr,
                                 input logic [NRF-1:0] mask, input logic [DATAW-1:0] data,
                                 input logic [DESTW-1:0] dest);
        cmd_op      = op;
        cmd_rf_addr = addr;
        cmd_rf_mask = mask;
        cmd_data    = data;
        cmd_dest    = dest;
        cmd_valid   = 1'b1;
        pushed      = 1'b0;
        for (int i = 0; i < 50 && !pushed; i++) step();
        cmd_valid = 1'b0;
        checkOutput("push_accepted", DATAW'(pushed), DATAW'(1'b1));
    endtask

    task automatic pushRandom();
        setRandomCmd();
        applyStimulus(cmd_op, cmd_rf_addr, cmd_rf_mask, cmd_data, cmd_dest);
    endtask

    task automatic drain();
        axis_tx_tready = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() > 0 || axis_tx_tvalid); i++) step();
        checkOutput("drain_done", DATAW'(exp_q.size()), DATAW'(0));
    endtask

    task automatic doReset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [DATAW-1:0] d;
        logic [DATAW-1:0] hold_data;
        logic [USERW-1:0] hold_user;
        int               b0;

        $display("[TB] start");
        step();
        step();
        checkOutput("rst_tvalid", DATAW'(axis_tx_tvalid), DATAW'(0));
        checkOutput("rst_tdata", axis_tx_tdata, DATAW'(0));
        checkOutput("rst_tuser", DATAW'(axis_tx_tuser), DATAW'(0));
        checkOutput("rst_tid", DATAW'(axis_tx_tid), DATAW'(0));
        checkOutput("rst_tdest", DATAW'(axis_tx_tdest), DATAW'(0));
        checkOutput("rst_tlast", DATAW'(axis_tx_tlast), DATAW'(0));
        checkOutput("rst_tkeep", DATAW'(axis_tx_tkeep), DATAW'(0));
        checkOutput("rst_tstrb", DATAW'(axis_tx_tstrb), DATAW'(0));
        checkOutput("rst_count", DATAW'(cmd_count), DATAW'(0));
        checkOutput("rst_ready_low", DATAW'(cmd_ready), DATAW'(0));
        rst = 1'b0;
        #1;
        checkOutput("rst_ready_high", DATAW'(cmd_ready), DATAW'(1));

        // RF write with full mask: one-cycle load latency, then the encoded beat.
        axis_tx_tready = 1'b1;
        applyStimulus(2'b11, 9'h001, {NRF{1'b1}}, randData(), 12'h000);
        checkOutput("t1_latency", DATAW'(axis_tx_tvalid), DATAW'(0));
        step();
        checkOutput("t1_tvalid", DATAW'(axis_tx_tvalid), DATAW'(1));
        checkOutput("t1_tuser", DATAW'(axis_tx_tuser), DATAW'({64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 9'h001}));
        checkOutput("t1_tlast", DATAW'(axis_tx_tlast), DATAW'(1));
        checkOutput("t1_tkeep", DATAW'(axis_tx_tkeep), DATAW'(8'hFF));
        checkOutput("t1_tid", DATAW'(axis_tx_tid), DATAW'(0));
        drain();

        // Instruction: upper payload bits must be cleared.
        d = randData();
        d[31:0] = 32'h8000200E;
        d[DATAW-1] = 1'b1;
        applyStimulus(2'b00, 9'h1AB, {NRF{1'b1}}, d, 12'h005);
        step();
        checkOutput("t2_tdata", axis_tx_tdata, DATAW'(32'h8000200E));
        checkOutput("t2_tuser", DATAW'(axis_tx_tuser), DATAW'(0));
        checkOutput("t2_tid", DATAW'(axis_tx_tid), DATAW'(1));
        drain();

        // Backpressure: queue fills behind a stalled beat, then empties back-to-back.
        doReset();
        axis_tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) pushRandom();
        checkOutput("t3_count_full", DATAW'(cmd_count), DATAW'(4));
        checkOutput("t3_ready_full", DATAW'(cmd_ready), DATAW'(0));
        checkOutput("t3_tvalid", DATAW'(axis_tx_tvalid), DATAW'(1));
        hold_data = axis_tx_tdata;
        hold_user = axis_tx_tuser;
        for (int i = 0; i < 10; i++) step();
        checkOutput("t3_hold_tdata", axis_tx_tdata, hold_data);
        checkOutput("t3_hold_tuser", DATAW'(axis_tx_tuser), DATAW'(hold_user));
        axis_tx_tready = 1'b1;
        b0 = beat_cnt;
        for (int i = 0; i < 5; i++) step();
        checkOutput("t3_burst_beats", DATAW'(beat_cnt - b0), DATAW'(5));
        checkOutput("t3_idle_after", DATAW'(axis_tx_tvalid), DATAW'(0));

        // Full queue released with a continuous command stream.
        axis_tx_tready = 1'b0;
        for (int i = 0; i < 5; i++) pushRandom();
        axis_tx_tready = 1'b1;
        cmd_valid = 1'b1;
        b0 = beat_cnt;
        for (int i = 0; i < 30; i++) begin
            setRandomCmd();
            if (i == 10) b0 = beat_cnt;
            step();
            checkOutput("t4_count_max", DATAW'(cmd_count <= 3'(CMDD)), DATAW'(1));
        end
        checkOutput("t4_throughput", DATAW'(beat_cnt - b0), DATAW'(20));
        cmd_valid = 1'b0;
        drain();

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            setRandomCmd();
            cmd_valid      = 1'($urandom_range(0, 1));
            axis_tx_tready = 1'($urandom_range(0, 1));
            step();
        end
        cmd_valid = 1'b0;
        drain();

        // Reset while a beat is stalled and three commands are queued.
        axis_tx_tready = 1'b0;
        for (int i = 0; i < 4; i++) pushRandom();
        checkOutput("t6_pre_count", DATAW'(cmd_count), DATAW'(3));
        checkOutput("t6_pre_tvalid", DATAW'(axis_tx_tvalid), DATAW'(1));
        rst = 1'b1;
        step();
        checkOutput("t6_tvalid", DATAW'(axis_tx_tvalid), DATAW'(0));
        checkOutput("t6_count", DATAW'(cmd_count), DATAW'(0));
        checkOutput("t6_tid", DATAW'(axis_tx_tid), DATAW'(0));
        checkOutput("t6_ready_in_rst", DATAW'(cmd_ready), DATAW'(0));
        rst = 1'b0;
        #1;
        checkOutput("t6_ready_after", DATAW'(cmd_ready), DATAW'(1));
        axis_tx_tready = 1'b1;
        pushRandom();
        step();
        checkOutput("t6_new_tvalid", DATAW'(axis_tx_tvalid), DATAW'(1));
        checkOutput("t6_new_tid", DATAW'(axis_tx_tid), DATAW'(0));
        drain();

`ifdef MVM_LOADER_STATS_EN
        doReset();
        axis_tx_tready = 1'b1;
        applyStimulus(2'b11, 9'h010, {NRF{1'b1}}, randData(), 12'h001);
        applyStimulus(2'b11, 9'h011, '0, randData(), 12'h001);
        applyStimulus(2'b10, 9'h000, '0, randData(), 12'h002);
        applyStimulus(2'b01, 9'h000, '0, randData(), 12'h003);
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 9'h000, '0, randData(), 12'h004);
        drain();
        step();
        checkOutput("stat_rf", DATAW'(stat_rf_cnt), DATAW'(2));
        checkOutput("stat_vec", DATAW'(stat_vec_cnt), DATAW'(1));
        checkOutput("stat_red", DATAW'(stat_red_cnt), DATAW'(1));
        checkOutput("stat_inst", DATAW'(stat_inst_cnt), DATAW'(3));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mvm_axis_loader.md
Name: mvm_axis_loader

Overview:
- AXI-Stream transmitter that builds single-beat command packets for the rtl_mvm receive port (axis_rx_*).
- A host or controller pushes typed commands (RF weight write, input vector, reduction vector, instruction) through a valid/ready interface.
- The block queues them, encodes the tuser sideband, and drives a compliant AXIS master with backpressure.
- It sits upstream of rtl_mvm, either in place of the bench driver or behind a NoC endpoint.

Parameters:
- DATAW, 512, tdata width.
- BYTEW, 8, tstrb/tkeep width.
- IDW, 32, tid width (packet sequence number).
- DESTW, 12, tdest width.
- USERW, 75, tuser width; must equal RFADDRW + 2 + NRF.
- RFADDRW, 9, register-file address width.
- NRF, 64, number of RF enable-mask bits.
- INSTW, 32, instruction word width carried in tdata[INSTW-1:0].
- CMDD, 4, command queue depth (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command queue can accept.
- cmd_op  in  2  11=RF write, 10=input vec, 01=reduction vec, 00=instruction.
- cmd_rf_addr  in  RFADDRW  RF address; used only for op 11.
- cmd_rf_mask  in  NRF  RF enable mask; used only for op 11.
- cmd_data  in  DATAW  payload.
- cmd_dest  in  DESTW  destination node.
- cmd_count  out  $clog2(CMDD)+1  queue occupancy.
- axis_tx_tvalid  out  1  AXIS valid.
- axis_tx_tdata  out  DATAW  payload.
- axis_tx_tstrb  out  BYTEW  byte strobes.
- axis_tx_tkeep  out  BYTEW  byte keeps.
- axis_tx_tid  out  IDW  packet sequence number.
- axis_tx_tdest  out  DESTW  destination.
- axis_tx_tuser  out  USERW  {mask, op, addr}.
- axis_tx_tlast  out  1  end of packet.
- axis_tx_tready  in  1  downstream ready.

Behaviour:
- Single clock domain; rst is synchronous active-high.
- Reset values: all axis_tx_* outputs 0; cmd_count 0; cmd_ready 0 during rst and 1 on the first cycle after.
- Queue: circular FIFO of CMDD entries holding {op, addr, mask, data, dest}.
- cmd_ready = !full. It is registered-only and has no combinational path from tready.
- A push happens when cmd_valid && cmd_ready at the clock edge.
- Output stage is a two-state machine:
  - EMPTY: tvalid=0; loads the FIFO head when the FIFO is non-empty, then moves to VALID.
  - VALID: tvalid=1. When tready=1, the beat completes. If the FIFO is non-empty, the next head loads in the same edge and the state stays VALID (back-to-back, one beat/cycle). Otherwise the state goes to EMPTY.
- Latency: a command pushed at edge E into an empty block shows tvalid=1 after edge E+1.
- Simultaneous push and pop is allowed; cmd_count is unchanged in that case.
- Pointers wrap modulo CMDD.
- AXIS rule: while tvalid && !tready, every axis_tx_* output is held stable. tvalid never drops without a handshake.
- Encoding on load:
  - tuser[RFADDRW-1:0] = addr if op==11, else 0.
  - tuser[RFADDRW+1:RFADDRW] = op.
  - tuser[USERW-1:RFADDRW+2] = mask if op==11, else 0.
  - tdata = cmd_data for ops 11/10/01. For op 00, tdata[INSTW-1:0] = cmd_data[INSTW-1:0] and the upper bits are 0.
  - tstrb = tkeep = all ones. tlast = 1 on every beat. tdest = cmd_dest.
- tid: a counter that starts at 0, increments on each completed handshake, and wraps at 2^IDW. The value presented is the count of beats already sent.
- Full FIFO with a pop in the same cycle: cmd_ready stays 0 that cycle and rises the next cycle.
- Reset mid-transfer: the queued commands and the beat in flight are discarded, tvalid=0 after the reset edge, and tid returns to 0.
- op 11 with mask 0 is transmitted unchanged; the block performs no validation.

Optional Feature:
- Macro: MVM_LOADER_STATS_EN.
- When defined, four extra output ports are added, each 32-bit: stat_rf_cnt, stat_vec_cnt, stat_red_cnt, stat_inst_cnt.
  - Each counts completed handshakes of ops 11/10/01/00 respectively.
  - Each wraps, resets to 0, and is registered.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Push op 11, addr 0x001, mask 0xFFFF_FFFF_FFFF_FFFF, data from rf_weights.in, dest 0, with tready=1 -> one beat after edge E+1: tuser = {64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 9'h001}, tlast=1, tkeep=8'hFF, tid=0.
- Push op 00 with cmd_data[31:0]=0x8000200E and non-zero upper bits -> tdata=0x8000200E zero-extended, tuser=75'h0, tid=1.
- Hold tready=0, push 5 commands -> cmd_ready=0 after 4 are accepted plus 1 loaded into the output stage; tdata/tuser are stable for 10 cycles. Release tready -> 5 back-to-back beats in push order, tid 0..4.
- Queue full and tready=1 with continuous cmd_valid -> throughput is 1 beat/cycle in steady state, and cmd_count never exceeds 4.
- Assert rst for 1 cycle while tvalid=1, tready=0, and 3 commands are queued -> tvalid=0, cmd_count=0, the next pushed command goes out with tid=0.
- With MVM_LOADER_STATS_EN: send 2×op 11, 1×op 10, 1×op 01, 3×op 00 -> stat counters read 2/1/1/3.
